// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, read-allocate data cache controller.
// Drives the external valid/tag/data arrays and requests from main memory.
// Optional macro INVALIDATE_EN adds a cpu_inv port and a single-line invalidate state.
module dcache_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned WORDS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef INVALIDATE_EN
  input  logic                          cpu_inv,
`endif
  input  logic                          cpu_req,
  input  logic                          cpu_wr,
  input  logic [15:0]                   cpu_addr,
  input  logic [15:0]                   cpu_wdata,
  output logic [15:0]                   cpu_rdata,
  output logic                          cpu_done,
  output logic                          cpu_stall,
  output logic [INDEX_W-1:0]            arr_index,
  output logic                          v_write,
  output logic                          v_data_in,
  input  logic                          v_data_out,
  output logic                          t_write,
  output logic [TAG_W-1:0]              t_data_in,
  input  logic [TAG_W-1:0]              t_data_out,
  output logic                          d_write,
  output logic [$clog2(WORDS)-1:0]      d_word,
  output logic [15:0]                   d_data_in,
  input  logic [15:0]                   d_data_out,
  output logic                          mem_req,
  output logic                          mem_wr,
  output logic [15:0]                   mem_addr,
  output logic [15:0]                   mem_wdata,
  input  logic [15:0]                   mem_rdata,
  input  logic                          mem_ack
);

  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_LO = WORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_UPDATE,
    S_WRITE
`ifdef INVALIDATE_EN
    , S_INV
`endif
  } state_t;

  state_t                    state_q;
  logic [ADDR_W-1:1]         addr_q;
  logic                      wr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [WORD_W-1:0]         cnt_q;

  logic [DATA_W-1:0]         cpu_rdata_q;
  logic                      cpu_done_q;
  logic                      cpu_stall_q;
  logic [INDEX_W-1:0]        arr_index_q;
  logic                      v_write_q;
  logic                      v_data_in_q;
  logic                      t_write_q;
  logic [TAG_W-1:0]          t_data_in_q;
  logic                      d_write_q;
  logic [WORD_W-1:0]         d_word_q;
  logic [DATA_W-1:0]         d_data_in_q;
  logic                      mem_req_q;
  logic                      mem_wr_q;
  logic [ADDR_W-1:0]         mem_addr_q;
  logic [DATA_W-1:0]         mem_wdata_q;

  logic [TAG_W-1:0]          tag_c;
  logic [INDEX_W-1:0]        idx_c;
  logic [WORD_W-1:0]         word_c;
  logic                      hit_c;
  logic                      unused_c;

  // Field split of the latched request address
  assign tag_c    = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_c    = addr_q[IDX_LO +: INDEX_W];
  assign word_c   = addr_q[1 +: WORD_W];
  assign hit_c    = v_data_out & (t_data_out == tag_c);
  assign unused_c = cpu_addr[0];

  // Controller state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_stall_q <= 1'b0;
      arr_index_q <= '0;
      v_write_q   <= 1'b0;
      v_data_in_q <= 1'b0;
      t_write_q   <= 1'b0;
      t_data_in_q <= '0;
      d_write_q   <= 1'b0;
      d_word_q    <= '0;
      d_data_in_q <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      v_write_q  <= 1'b0;
      t_write_q  <= 1'b0;
      d_write_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef INVALIDATE_EN
          if (cpu_inv && !cpu_done_q) begin
            addr_q      <= cpu_addr[ADDR_W-1:1];
            arr_index_q <= cpu_addr[IDX_LO +: INDEX_W];
            v_write_q   <= 1'b1;
            v_data_in_q <= 1'b0;
            cpu_stall_q <= 1'b1;
            state_q     <= S_INV;
          end else
`endif
          if (cpu_req && !cpu_done_q) begin
            addr_q      <= cpu_addr[ADDR_W-1:1];
            wr_q        <= cpu_wr;
            wdata_q     <= cpu_wdata;
            arr_index_q <= cpu_addr[IDX_LO +: INDEX_W];
            d_word_q    <= cpu_addr[1 +: WORD_W];
            cpu_stall_q <= 1'b1;
            state_q     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (!wr_q && hit_c) begin
            cpu_rdata_q <= d_data_out;
            cpu_done_q  <= 1'b1;
            cpu_stall_q <= 1'b0;
            state_q     <= S_IDLE;
          end else if (!wr_q) begin
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {tag_c, idx_c, WORD_W'(0), 1'b0};
            state_q    <= S_FILL;
          end else begin
            // Write-through: update the line only when already resident
            if (hit_c) begin
              d_write_q   <= 1'b1;
              d_data_in_q <= wdata_q;
            end
            mem_req_q   <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= {addr_q, 1'b0};
            mem_wdata_q <= wdata_q;
            state_q     <= S_WRITE;
          end
        end

        S_FILL: begin
          if (mem_req_q && mem_ack) begin
            d_write_q   <= 1'b1;
            d_word_q    <= cnt_q;
            d_data_in_q <= mem_rdata;
            if (cnt_q == word_c) begin
              cpu_rdata_q <= mem_rdata;
            end
            cnt_q <= cnt_q + WORD_W'(1);
            if (cnt_q == WORD_W'(WORDS - 1)) begin
              // Line complete: mark valid and record tag in the next cycle
              mem_req_q   <= 1'b0;
              v_write_q   <= 1'b1;
              v_data_in_q <= 1'b1;
              t_write_q   <= 1'b1;
              t_data_in_q <= tag_c;
              state_q     <= S_UPDATE;
            end else begin
              mem_addr_q <= {tag_c, idx_c, cnt_q + WORD_W'(1), 1'b0};
            end
          end
        end

        S_UPDATE: begin
          cpu_done_q  <= 1'b1;
          cpu_stall_q <= 1'b0;
          state_q     <= S_IDLE;
        end

        S_WRITE: begin
          if (mem_req_q && mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            cpu_done_q  <= 1'b1;
            cpu_stall_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

`ifdef INVALIDATE_EN
        S_INV: begin
          cpu_done_q  <= 1'b1;
          cpu_stall_q <= 1'b0;
          state_q     <= S_IDLE;
        end
`endif

        default: begin
          cpu_stall_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_stall = cpu_stall_q;
  assign arr_index = arr_index_q;
  assign v_write   = v_write_q;
  assign v_data_in = v_data_in_q;
  assign t_write   = t_write_q;
  assign t_data_in = t_data_in_q;
  assign d_write   = d_write_q;
  assign d_word    = d_word_q;
  assign d_data_in = d_data_in_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: models the valid/tag/data arrays and a
// main memory that acks each request a few cycles after it appears.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
`ifdef INVALIDATE_EN
  logic        cpu_inv;
`endif
  logic        cpu_req, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic [7:0]  arr_index;
  logic        v_write, v_data_in, v_data_out;
  logic        t_write;
  logic [4:0]  t_data_in, t_data_out;
  logic        d_write;
  logic [1:0]  d_word;
  logic [15:0] d_data_in, d_data_out;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;

  logic        vmem [256];
  logic [4:0]  tmem [256];
  logic [15:0] dmem [1024];
  logic [15:0] mem  [32768];

  int dw_cnt = 0, vw_cnt = 0, tw_cnt = 0, mreq_cnt = 0;
  logic [15:0] log_addr [$];
  logic        log_wr   [$];
  logic [15:0] log_data [$];

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef INVALIDATE_EN
    .cpu_inv(cpu_inv),
`endif
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .arr_index(arr_index),
    .v_write(v_write), .v_data_in(v_data_in), .v_data_out(v_data_out),
    .t_write(t_write), .t_data_in(t_data_in), .t_data_out(t_data_out),
    .d_write(d_write), .d_word(d_word), .d_data_in(d_data_in), .d_data_out(d_data_out),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  assign v_data_out = v_write ? 1'b0 : vmem[arr_index];
  assign t_data_out = tmem[arr_index];
  assign d_data_out = dmem[{arr_index, d_word}];

  // Array storage and write-enable activity counters
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) vmem[i] <= 1'b0;
    end else begin
      if (v_write) vmem[arr_index] <= v_data_in;
      if (t_write) tmem[arr_index] <= t_data_in;
      if (d_write) dmem[{arr_index, d_word}] <= d_data_in;
    end
    if (v_write) vw_cnt <= vw_cnt + 1;
    if (t_write) tw_cnt <= tw_cnt + 1;
    if (d_write) dw_cnt <= dw_cnt + 1;
    if (mem_req) mreq_cnt <= mreq_cnt + 1;
  end

  // Main memory responder: one-cycle ack after a short wait, logs each transfer
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2) ^ 16'h5A00;
    mem[16'h1234 >> 1] = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (rst || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= 1) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[15:1]];
        if (mem_wr) mem[mem_addr[15:1]] = mem_wdata;
        log_addr.push_back(mem_addr);
        log_wr.push_back(mem_wr);
        log_data.push_back(mem_wdata);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output int lat);
    @(negedge clk);
    cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_done) break;
    end
    chk("done_seen", 32'(cpu_done), 32'd1);
    rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int lat, l0, dw0, vw0, tw0, mr0;

    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef INVALIDATE_EN
    cpu_inv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_done",  32'(cpu_done),  32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mreq",  32'(mem_req),   32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_maddr", 32'(mem_addr),  32'd0);
    chk("rst_index", 32'(arr_index), 32'd0);
    chk("rst_writes", 32'({v_write, t_write, d_write}), 32'd0);
    rst = 1'b0;

    // Cold miss on 0x1234: four-word fill, requested word returned
    l0 = log_addr.size(); dw0 = dw_cnt;
    do_op(1'b0, 16'h1234, 16'h0, rd, lat);
    chk("fill1_rdata", 32'(rd), 32'hBEEF);
    chk("fill1_ntx", 32'(log_addr.size() - l0), 32'd4);
    chk("fill1_a0", 32'(log_addr[l0]),   32'h1230);
    chk("fill1_a1", 32'(log_addr[l0+1]), 32'h1232);
    chk("fill1_a2", 32'(log_addr[l0+2]), 32'h1234);
    chk("fill1_a3", 32'(log_addr[l0+3]), 32'h1236);
    chk("fill1_rd", 32'({log_wr[l0], log_wr[l0+3]}), 32'd0);
    chk("fill1_valid", 32'(vmem[8'h46]), 32'd1);
    chk("fill1_tag", 32'(tmem[8'h46]), 32'd2);
    chk("fill1_word0", 32'(dmem[{8'h46, 2'd0}]), 32'h4830);
    chk("fill1_dw", 32'(dw_cnt - dw0), 32'd4);

    // Re-read: hit, 2-cycle latency, no memory traffic
    l0 = log_addr.size(); mr0 = mreq_cnt;
    do_op(1'b0, 16'h1234, 16'h0, rd, lat);
    chk("hit_rdata", 32'(rd), 32'hBEEF);
    chk("hit_lat", 32'(lat), 32'd2);
    chk("hit_mreq", 32'(mreq_cnt - mr0), 32'd0);
    chk("hit_ntx", 32'(log_addr.size() - l0), 32'd0);

    // Conflict miss on same index with tag 3
    l0 = log_addr.size();
    do_op(1'b0, 16'h1A34, 16'h0, rd, lat);
    chk("conf_rdata", 32'(rd), 32'h4034);
    chk("conf_ntx", 32'(log_addr.size() - l0), 32'd4);
    chk("conf_a0", 32'(log_addr[l0]), 32'h1A30);
    chk("conf_a3", 32'(log_addr[l0+3]), 32'h1A36);
    chk("conf_tag", 32'(tmem[8'h46]), 32'd3);

    // Original address now misses
    l0 = log_addr.size();
    do_op(1'b0, 16'h1234, 16'h0, rd, lat);
    chk("evict_ntx", 32'(log_addr.size() - l0), 32'd4);
    chk("evict_rdata", 32'(rd), 32'hBEEF);

    // Bring tag 3 back, then write-hit 0x1A36
    do_op(1'b0, 16'h1A34, 16'h0, rd, lat);
    l0 = log_addr.size(); dw0 = dw_cnt; vw0 = vw_cnt; tw0 = tw_cnt;
    do_op(1'b1, 16'h1A36, 16'h5555, rd, lat);
    chk("wh_ntx", 32'(log_addr.size() - l0), 32'd1);
    chk("wh_addr", 32'(log_addr[l0]), 32'h1A36);
    chk("wh_wr", 32'(log_wr[l0]), 32'd1);
    chk("wh_data", 32'(log_data[l0]), 32'h5555);
    chk("wh_dw", 32'(dw_cnt - dw0), 32'd1);
    chk("wh_word3", 32'(dmem[{8'h46, 2'd3}]), 32'h5555);
    chk("wh_vtw", 32'((vw_cnt - vw0) + (tw_cnt - tw0)), 32'd0);

    l0 = log_addr.size();
    do_op(1'b0, 16'h1A36, 16'h0, rd, lat);
    chk("wh_rb_rdata", 32'(rd), 32'h5555);
    chk("wh_rb_lat", 32'(lat), 32'd2);
    chk("wh_rb_ntx", 32'(log_addr.size() - l0), 32'd0);

    // Write miss: memory write only, no allocation
    l0 = log_addr.size(); dw0 = dw_cnt; vw0 = vw_cnt; tw0 = tw_cnt;
    do_op(1'b1, 16'h0F00, 16'h1111, rd, lat);
    chk("wm_ntx", 32'(log_addr.size() - l0), 32'd1);
    chk("wm_addr", 32'(log_addr[l0]), 32'h0F00);
    chk("wm_wr", 32'(log_wr[l0]), 32'd1);
    chk("wm_data", 32'(log_data[l0]), 32'h1111);
    chk("wm_arr", 32'((dw_cnt - dw0) + (vw_cnt - vw0) + (tw_cnt - tw0)), 32'd0);
    chk("wm_valid", 32'(vmem[8'hE0]), 32'd0);

    // Reset in the middle of a fill, after the second ack
    l0 = log_addr.size(); vw0 = vw_cnt; tw0 = tw_cnt;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_addr = 16'h2468; cpu_req = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if ((log_addr.size() - l0) >= 2 && !mem_ack) break;
    end
    chk("mid_acks", 32'(log_addr.size() - l0), 32'd2);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_mreq", 32'(mem_req), 32'd0);
    chk("mid_stall", 32'(cpu_stall), 32'd0);
    chk("mid_vtw", 32'((vw_cnt - vw0) + (tw_cnt - tw0)), 32'd0);
    rst = 1'b0;
    l0 = log_addr.size();
    do_op(1'b0, 16'h2468, 16'h0, rd, lat);
    chk("refetch_ntx", 32'(log_addr.size() - l0), 32'd4);
    chk("refetch_a0", 32'(log_addr[l0]), 32'h2468);
    chk("refetch_a3", 32'(log_addr[l0+3]), 32'h246E);
    chk("refetch_rdata", 32'(rd), 32'h7E68);

`ifdef INVALIDATE_EN
    do_op(1'b0, 16'h1234, 16'h0, rd, lat);
    chk("inv_fill_valid", 32'(vmem[8'h46]), 32'd1);
    l0 = log_addr.size();
    @(negedge clk);
    cpu_addr = 16'h1234; cpu_inv = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_done) break;
    end
    cpu_inv = 1'b0;
    chk("inv_lat", 32'(lat), 32'd2);
    chk("inv_valid", 32'(vmem[8'h46]), 32'd0);
    chk("inv_ntx", 32'(log_addr.size() - l0), 32'd0);
    l0 = log_addr.size();
    do_op(1'b0, 16'h1234, 16'h0, rd, lat);
    chk("inv_miss_ntx", 32'(log_addr.size() - l0), 32'd4);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
